// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one fixed-latency single-port memory between fetch and the data path.
// Optional macro MEM_ARB_RR_EN enables round-robin arbitration on ties (default: data priority).
// Revision: 1.0
`default_nettype none

`ifndef MEM_OP_BITS
`define MEM_OP_BITS 2
`endif
`ifndef MEM_OP_NOP
`define MEM_OP_NOP 2'd0
`endif
`ifndef MEM_OP_READ
`define MEM_OP_READ 2'd1
`endif
`ifndef MEM_OP_WRITE
`define MEM_OP_WRITE 2'd2
`endif

module mem_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int MEM_LATENCY = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    if_req,
  input  logic [ADDR_W-1:0]       if_addr,
  output logic [DATA_W-1:0]       if_rdata,
  output logic                    if_ack,
  input  logic [`MEM_OP_BITS-1:0] d_op,
  input  logic [ADDR_W-1:0]       d_addr,
  input  logic [DATA_W-1:0]       d_wdata,
  output logic [DATA_W-1:0]       d_rdata,
  output logic                    d_ack,
  output logic                    mem_en,
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [DATA_W-1:0]       mem_wdata,
  input  logic [DATA_W-1:0]       mem_rdata,
  output logic                    busy,
  output logic                    stall_if
);

  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  if (MEM_LATENCY < 1) begin : g_latency_check
    $error("mem_arbiter: MEM_LATENCY must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [CNT_W-1:0]    count;
  logic                win_data;
  logic                lat_we;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;
  logic                d_pend;
  logic                any_req;
  logic                grant_data;

  assign d_pend  = (d_op != `MEM_OP_NOP);
  assign any_req = if_req | d_pend;

`ifdef MEM_ARB_RR_EN
  // Set when fetch took the most recent grant; reset value hands the first tie to data.
  logic rr_last_fetch;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_last_fetch <= 1'b1;
    end else if (state == IDLE && any_req) begin
      rr_last_fetch <= ~grant_data;
    end
  end

  assign grant_data = d_pend & (~if_req | rr_last_fetch);
`else
  assign grant_data = d_pend;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ACCESS;
      ACCESS:  if (count == '0) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request latches and read-data registers; inputs are only looked at in IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count     <= '0;
      win_data  <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            win_data  <= grant_data;
            lat_we    <= grant_data & (d_op == `MEM_OP_WRITE);
            lat_addr  <= grant_data ? d_addr : if_addr;
            lat_wdata <= d_wdata;
            count     <= CNT_W'(MEM_LATENCY - 1);
          end
        end
        ACCESS: begin
          if (count != '0) begin
            count <= count - CNT_W'(1);
          end else if (!lat_we) begin
            if (win_data) d_rdata  <= mem_rdata;
            else          if_rdata <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_en    = (state == ACCESS);
  assign mem_we    = mem_en & lat_we;
  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;
  assign if_ack    = (state == RESP) & ~win_data;
  assign d_ack     = (state == RESP) & win_data;
  assign busy      = (state != IDLE);
  assign stall_if  = d_pend | (busy & win_data);

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table-driven vectors with an ack scoreboard, plus multi-cycle corner sequences.
// Revision: 1.0
`default_nettype none

`ifndef MEM_OP_BITS
`define MEM_OP_BITS 2
`endif
`ifndef MEM_OP_NOP
`define MEM_OP_NOP 2'd0
`endif
`ifndef MEM_OP_READ
`define MEM_OP_READ 2'd1
`endif
`ifndef MEM_OP_WRITE
`define MEM_OP_WRITE 2'd2
`endif

module tb_mem_arbiter;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic                    if_req, if_ack, d_ack, mem_en, mem_we, busy, stall_if;
  logic [15:0]             if_addr, if_rdata, d_addr, d_wdata, d_rdata;
  logic [15:0]             mem_addr, mem_wdata, mem_rdata, mem_val;
  logic [`MEM_OP_BITS-1:0] d_op;

  logic                    if_req1, if_ack1, d_ack1, mem_en1, mem_we1, busy1, stall_if1;
  logic [15:0]             if_addr1, if_rdata1, d_rdata1, mem_addr1, mem_wdata1, mem_rdata1;

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LATENCY(LAT)) dut0 (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_op(d_op), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .stall_if(stall_if)
  );

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset),
    .if_req(if_req1), .if_addr(if_addr1), .if_rdata(if_rdata1), .if_ack(if_ack1),
    .d_op(`MEM_OP_NOP), .d_addr(16'h0000), .d_wdata(16'h0000), .d_rdata(d_rdata1), .d_ack(d_ack1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata1), .busy(busy1), .stall_if(stall_if1)
  );

  // Memory model: data is only valid in the last enabled cycle of an access.
  int en_cnt;
  always @(posedge clk or posedge reset) begin
    if (reset) en_cnt <= 0;
    else       en_cnt <= mem_en ? en_cnt + 1 : 0;
  end
  assign mem_rdata  = (mem_en && en_cnt == LAT - 1) ? mem_val : 16'hDEAD;
  assign mem_rdata1 = mem_en1 ? 16'hC3C3 : 16'hDEAD;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic                    ifr;
    logic [15:0]             ia;
    logic [`MEM_OP_BITS-1:0] op;
    logic [15:0]             da;
    logic [15:0]             dw;
    logic [15:0]             mv;
    logic                    exp_fetch;
    logic [15:0]             exp_rdata;
  } vec_t;

  typedef struct {
    logic [15:0] addr;
    logic        we;
    logic [15:0] wdata;
    logic        fetch;
    logic [15:0] rdata;
  } exp_t;

  exp_t q[$];

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (mem_en) begin
        if (q.size() == 0) check("mem_en_unexpected", 1, 0);
        else begin
          check("mem_addr", mem_addr, q[0].addr);
          check("mem_we", mem_we, q[0].we);
          if (q[0].we) check("mem_wdata", mem_wdata, q[0].wdata);
        end
      end
      if (if_ack || d_ack) begin
        if (q.size() == 0) check("ack_unexpected", 1, 0);
        else begin
          e = q.pop_front();
          check("ack_src", {if_ack, d_ack}, {e.fetch, ~e.fetch});
          check("ack_rdata", e.fetch ? if_rdata : d_rdata, e.rdata);
        end
      end
    end
  end

  task automatic push_exp(input vec_t v);
    exp_t e;
    e.addr  = v.exp_fetch ? v.ia : v.da;
    e.we    = !v.exp_fetch && (v.op == `MEM_OP_WRITE);
    e.wdata = v.dw;
    e.fetch = v.exp_fetch;
    e.rdata = v.exp_rdata;
    q.push_back(e);
  endtask

  task automatic run_vec(input vec_t v);
    int k;
    bit got;
    @(posedge clk); #1;
    if_req = v.ifr; if_addr = v.ia; d_op = v.op; d_addr = v.da; d_wdata = v.dw; mem_val = v.mv;
    push_exp(v);
    k = 0; got = 0;
    while (k < 12 && !got) begin
      @(negedge clk);
      if (k == 0) check("stall_idle", stall_if, (v.op != `MEM_OP_NOP));
      if (if_ack || d_ack) got = 1;
      else k++;
    end
    check("latency", k, LAT + 1);
    @(posedge clk); #1;
    if_req = 1'b0; d_op = `MEM_OP_NOP;
    @(negedge clk);
    check("busy_after", busy, 0);
  endtask

  vec_t vecs[6];
  vec_t v;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got 0x0, expected 0x1");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks, cyc;
    logic [2:0] grants, exp_grants;

    vecs[0] = '{1'b1, 16'h0040, `MEM_OP_NOP,   16'h0000, 16'h0000, 16'hBEEF, 1'b1, 16'hBEEF};
    vecs[1] = '{1'b0, 16'h0000, `MEM_OP_WRITE, 16'h0100, 16'h1234, 16'h9999, 1'b0, 16'h0000};
    vecs[2] = '{1'b0, 16'h0000, `MEM_OP_READ,  16'h0200, 16'h0000, 16'h5A5A, 1'b0, 16'h5A5A};
    vecs[3] = '{1'b0, 16'h0000, `MEM_OP_WRITE, 16'h0300, 16'hFFFF, 16'h1111, 1'b0, 16'h5A5A};
    vecs[4] = '{1'b1, 16'hFFFF, `MEM_OP_NOP,   16'h0000, 16'h0000, 16'h0001, 1'b1, 16'h0001};
    vecs[5] = '{1'b0, 16'h0000, `MEM_OP_READ,  16'h0000, 16'h0000, 16'h8001, 1'b0, 16'h8001};

    reset = 1'b1;
    if_req = 0; if_addr = 0; d_op = `MEM_OP_NOP; d_addr = 0; d_wdata = 0; mem_val = 0;
    if_req1 = 0; if_addr1 = 0;
    #12;
    check("rst_mem_en", mem_en, 0);
    check("rst_busy", busy, 0);
    check("rst_acks", {if_ack, d_ack}, 0);
    check("rst_rdata", {if_rdata, d_rdata}, 0);
    check("rst_mem_bus", {mem_we, mem_addr, mem_wdata}, 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Latched address must ignore a mid-access change of d_addr.
    @(posedge clk); #1;
    d_op = `MEM_OP_READ; d_addr = 16'h0010; mem_val = 16'h2468;
    v = '{1'b0, 16'h0000, `MEM_OP_READ, 16'h0010, 16'h0000, 16'h2468, 1'b0, 16'h2468};
    push_exp(v);
    @(posedge clk); #1;
    d_addr = 16'h0020;
    @(negedge clk);
    check("addr_hold", mem_addr, 16'h0010);
    cyc = 0;
    while (cyc < 10 && !d_ack) begin @(negedge clk); cyc++; end
    check("addr_hold_ack", d_ack, 1);
    @(posedge clk); #1;
    d_op = `MEM_OP_NOP;

    // Fetch-only grant so a round-robin pointer records fetch as last winner.
    v = '{1'b1, 16'h0070, `MEM_OP_NOP, 16'h0000, 16'h0000, 16'h0707, 1'b1, 16'h0707};
    run_vec(v);

    // Both requesters held continuously.
`ifdef MEM_ARB_RR_EN
    exp_grants = 3'b010;
`else
    exp_grants = 3'b000;
`endif
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 16'h0044; d_op = `MEM_OP_READ; d_addr = 16'h0088; mem_val = 16'h7777;
    for (int i = 0; i < 3; i++) begin
      v = '{1'b1, 16'h0044, `MEM_OP_READ, 16'h0088, 16'h0000, 16'h7777, exp_grants[i], 16'h7777};
      push_exp(v);
    end
    acks = 0; cyc = 0; grants = 3'b000;
    while (cyc < 40 && acks < 3) begin
      @(negedge clk);
      check("stall_hold", stall_if, 1);
      if (if_ack || d_ack) begin
        grants[acks] = if_ack;
        acks++;
      end
      cyc++;
    end
    check("tie_ack_count", acks, 3);
    check("tie_grants", grants, exp_grants);
    @(posedge clk); #1;
    if_req = 1'b0; d_op = `MEM_OP_NOP;

    // Asynchronous reset in the middle of a read.
    @(posedge clk); #1;
    d_op = `MEM_OP_READ; d_addr = 16'h0300; mem_val = 16'h1357;
    v = '{1'b0, 16'h0000, `MEM_OP_READ, 16'h0300, 16'h0000, 16'h1357, 1'b0, 16'h1357};
    push_exp(v);
    @(posedge clk);
    @(posedge clk); #2;
    reset = 1'b1;
    q.delete();
    #1;
    check("arst_mem_en", mem_en, 0);
    check("arst_acks", {if_ack, d_ack}, 0);
    check("arst_busy", busy, 0);
    @(negedge clk);
    d_op = `MEM_OP_NOP;
    reset = 1'b0;
    v = '{1'b0, 16'h0000, `MEM_OP_READ, 16'h0400, 16'h0000, 16'h4242, 1'b0, 16'h4242};
    run_vec(v);

    // Single-cycle memory with fetch held: one ack every three cycles.
    @(posedge clk); #1;
    if_req1 = 1'b1; if_addr1 = 16'h0050;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      check("lat1_mem_en", mem_en1, (k % 3 == 1));
      check("lat1_if_ack", if_ack1, (k % 3 == 2));
      if (k % 3 == 2) check("lat1_rdata", if_rdata1, 16'hC3C3);
    end
    @(posedge clk); #1;
    if_req1 = 1'b0;
    repeat (3) @(posedge clk);
    check("queue_drained", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
